// File: rtl/iexec_if_t.sv
// Fetch-to-execute request channel: the instruction word and its address, with a valid/ready handshake.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

interface iexec_if_t;
    typedef struct packed {
        logic [`RV_IR_SIZE-1:0] ir;
        logic [`RV_XLEN-1:0]    pc;
    } req_pkt_t;

    logic     req_vld;
    logic     req_rdy;
    req_pkt_t req_pkt;

    modport master (output req_vld, output req_pkt, input req_rdy);
    modport slave  (input req_vld, input req_pkt, output req_rdy);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order fetches with credit control and buffers words for execute.
// Defining IFU_BYPASS_EN lets a response reach execute in the same cycle when the buffer is empty.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

module ifu_fetch #(
    parameter logic [`RV_XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int                  FIFO_DEPTH      = 4,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fch_req_vld,
    input  logic                   fch_req_rdy,
    output logic [`RV_XLEN-1:0]    fch_req_addr,
    input  logic                   fch_rsp_vld,
    input  logic [`RV_IR_SIZE-1:0] fch_rsp_data,
    input  logic                   redir_vld,
    input  logic [`RV_XLEN-1:0]    redir_pc,
    iexec_if_t.master              iexec
);
    localparam int XW = `RV_XLEN;
    localparam int IW = `RV_IR_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] disc_q, disc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    logic [IW-1:0] fifo_ir [FIFO_DEPTH];
    logic [XW-1:0] fifo_pc [FIFO_DEPTH];
    logic [XW-1:0] pcq_mem [MAX_OUTSTANDING];

    logic          fch_hs, rsp_keep, byp, out_vld, fifo_push, fifo_pop;
    logic [XW-1:0] pcq_head;
    logic          unused_redir_lsb;

    function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + QW'(1);
    endfunction

    assign unused_redir_lsb = ^redir_pc[1:0];

    // Words still owed to the buffer (in flight minus those to be dropped) count against its free space.
    assign fch_req_vld  = !rst && (int'(outst_q) < MAX_OUTSTANDING)
                       && (int'(outst_q) - int'(disc_q) + int'(cnt_q) < FIFO_DEPTH);
    assign fch_req_addr = pc_q;
    assign fch_hs       = fch_req_vld && fch_req_rdy;

    assign pcq_head = pcq_mem[pcq_rd_q];
    assign rsp_keep = fch_rsp_vld && !redir_vld && (disc_q == '0);

`ifdef IFU_BYPASS_EN
    assign byp = rsp_keep && (cnt_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign out_vld   = (cnt_q != '0) || byp;
    assign fifo_pop  = out_vld && iexec.req_rdy && !byp;
    assign fifo_push = rsp_keep && !(byp && iexec.req_rdy);

    assign iexec.req_vld    = out_vld;
    assign iexec.req_pkt.ir = byp ? fch_rsp_data : fifo_ir[rd_ptr_q];
    assign iexec.req_pkt.pc = byp ? pcq_head : fifo_pc[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        outst_d  = outst_q + OW'(fch_hs) - OW'(fch_rsp_vld);
        disc_d   = disc_q;
        wr_ptr_d = fifo_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        pcq_wr_d = fch_hs ? pcq_inc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d = fch_rsp_vld ? pcq_inc(pcq_rd_q) : pcq_rd_q;

        if (fch_hs) begin
            pc_d = pc_q + XW'(4);
        end
        if (fch_rsp_vld && (disc_q != '0)) begin
            disc_d = disc_q - OW'(1);
        end
        // Everything still in flight after this cycle belongs to the old stream.
        if (redir_vld) begin
            pc_d     = {redir_pc[XW-1:2], 2'b00};
            disc_d   = outst_d;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pcq_wr_q <= pcq_wr_d;
            pcq_rd_q <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_ir[wr_ptr_q] <= fch_rsp_data;
            fifo_pc[wr_ptr_q] <= pcq_head;
        end
        if (fch_hs) begin
            pcq_mem[pcq_wr_q] <= pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && (cnt_q == CW'(FIFO_DEPTH))));
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
        !(fch_rsp_vld && (outst_q == '0)));
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: in-order bus model plus a program-order reference of fetch and delivery addresses.
`timescale 1ns/1ps
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int FDEPTH = 4;
    localparam int MAXO   = 2;
`ifdef IFU_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst, fch_req_vld, fch_req_rdy, fch_rsp_vld, redir_vld;
    logic [31:0] fch_req_addr, fch_rsp_data, redir_pc;

    iexec_if_t iexec_bus ();

    ifu_fetch #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (FDEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fch_req_vld (fch_req_vld),
        .fch_req_rdy (fch_req_rdy),
        .fch_req_addr(fch_req_addr),
        .fch_rsp_vld (fch_rsp_vld),
        .fch_rsp_data(fch_rsp_data),
        .redir_vld   (redir_vld),
        .redir_pc    (redir_pc),
        .iexec       (iexec_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_ent_t;

    bus_ent_t    bq[$];
    int          cyc_n = 0;
    bit          bus_rand = 0;
    bit          rsp_en = 1;
    int          lat_max = 1;
    logic        s_fvld, s_fhs, s_rvld, s_rhs;
    logic [31:0] s_faddr, s_rpc, s_rir;
    int          total = 0;
    int          bad = 0;
    int          nf = 0;
    int          nd = 0;
    logic [31:0] exp_fa, exp_dpc;

    function automatic logic [31:0] ir_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock: drive bus inputs, sample DUT at negedge, advance the bus model after posedge.
    task automatic cyc();
        fch_req_rdy = bus_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bq.size() > 0 && bq[0].due <= cyc_n && rsp_en && (!bus_rand || $urandom_range(0, 3) != 0)) begin
            fch_rsp_vld  = 1'b1;
            fch_rsp_data = ir_of(bq[0].addr);
        end else begin
            fch_rsp_vld  = 1'b0;
            fch_rsp_data = $urandom;
        end
        @(negedge clk);
        s_fvld  = fch_req_vld;
        s_faddr = fch_req_addr;
        s_fhs   = fch_req_vld && fch_req_rdy;
        s_rvld  = iexec_bus.req_vld;
        s_rpc   = iexec_bus.req_pkt.pc;
        s_rir   = iexec_bus.req_pkt.ir;
        s_rhs   = iexec_bus.req_vld && iexec_bus.req_rdy;
        @(posedge clk);
        if (rst) begin
            bq.delete();
        end else begin
            if (fch_rsp_vld) void'(bq.pop_front());
            if (s_fhs) bq.push_back('{s_faddr, cyc_n + (bus_rand ? int'($urandom_range(1, lat_max)) : 1)});
        end
        if (s_fhs === 1'b1) nf++;
        if (s_rhs === 1'b1) nd++;
        cyc_n++;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        redir_vld = 1'b0;
        iexec_bus.req_rdy = 1'b0;
        rsp_en = 1'b1;
        bus_rand = 1'b0;
        lat_max = 1;
        cyc();
        cyc();
        rst = 1'b0;
        nf = 0;
        nd = 0;
        exp_fa = RESET_PC;
        exp_dpc = RESET_PC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redir_vld = 1'b0;
        iexec_bus.req_rdy = 1'b0;
        cyc();
        cyc();
        total++; if (s_fvld !== 1'b0) begin bad++; $display("FAIL reset_fch_vld: got %b want 0", s_fvld); end
        total++; if (s_rvld !== 1'b0) begin bad++; $display("FAIL reset_req_vld: got %b want 0", s_rvld); end
        rst = 1'b0;
        cyc();
        total++; if (s_fvld !== 1'b1) begin bad++; $display("FAIL reset_first_fetch: got %b want 1", s_fvld); end
        total++; if (s_faddr !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", s_faddr, RESET_PC); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        int first_f = -1;
        int first_d = -1;
        apply_reset();
        iexec_bus.req_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (s_fhs) begin
                if (first_f < 0) first_f = i;
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL stream_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                if (first_d < 0) first_d = i;
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL stream_deliver: got pc=%h ir=%h want pc=%h ir=%h", s_rpc, s_rir, exp_dpc, ir_of(exp_dpc));
                end
                exp_dpc += 32'd4;
            end
        end
        total++; if (first_d - first_f != EXP_LAT) begin bad++; $display("FAIL stream_latency: got %0d want %0d", first_d - first_f, EXP_LAT); end
        total++; if (nf != 24) begin bad++; $display("FAIL stream_fetch_rate: got %0d want 24", nf); end
        total++; if (nd < 22) begin bad++; $display("FAIL stream_throughput: got %0d want >=22", nd); end
        $display("test_stream done: fetched=%0d delivered=%0d", nf, nd);
    endtask

    task automatic test_stall();
        bit          hold = 0;
        logic [31:0] hpc, hir;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            iexec_bus.req_rdy = (i < 6 || i >= 16);
            cyc();
            if (hold) begin
                total++;
                if (s_rvld !== 1'b1 || s_rpc !== hpc || s_rir !== hir) begin
                    bad++; $display("FAIL stall_hold: got vld=%b pc=%h ir=%h want vld=1 pc=%h ir=%h", s_rvld, s_rpc, s_rir, hpc, hir);
                end
            end
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL stall_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL stall_deliver: got pc=%h ir=%h want pc=%h", s_rpc, s_rir, exp_dpc);
                end
                exp_dpc += 32'd4;
            end
            if (i == 15) begin
                total++; if (s_fvld !== 1'b0) begin bad++; $display("FAIL stall_no_fetch: got %b want 0", s_fvld); end
                total++; if (nf - nd - bq.size() != FDEPTH) begin bad++; $display("FAIL stall_buffered: got %0d want %0d", nf - nd - bq.size(), FDEPTH); end
            end
            hold = (s_rvld === 1'b1) && (s_rhs !== 1'b1);
            hpc = s_rpc;
            hir = s_rir;
        end
        total++; if (nd < 16) begin bad++; $display("FAIL stall_drain: got %0d want >=16", nd); end
        $display("test_stall done: delivered=%0d", nd);
    endtask

    task automatic test_redirect_inflight();
        int n_after = 0;
        bit first = 1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rsp_en = (i == 2 || i == 3);
            redir_vld = (i == 5);
            redir_pc = 32'h0000_0103;
            if (i == 5) begin
                total++; if (bq.size() != 2) begin bad++; $display("FAIL redir_inflight_setup: got %0d want 2", bq.size()); end
            end
            cyc();
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL redir_pre_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
        end
        redir_vld = 1'b0;
        rsp_en = 1'b1;
        iexec_bus.req_rdy = 1'b1;
        exp_fa = 32'h0000_0100;
        exp_dpc = 32'h0000_0100;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 0) begin
                total++; if (s_rvld !== 1'b0) begin bad++; $display("FAIL redir_flushed: got vld=%b pc=%h want vld=0", s_rvld, s_rpc); end
            end
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL redir_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                if (first) begin
                    total++; if (s_rpc !== 32'h0000_0100) begin bad++; $display("FAIL redir_first_pc: got %h want 00000100", s_rpc); end
                    first = 0;
                end
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL redir_deliver: got pc=%h ir=%h want pc=%h", s_rpc, s_rir, exp_dpc);
                end
                exp_dpc += 32'd4;
                n_after++;
            end
        end
        total++; if (n_after < 5) begin bad++; $display("FAIL redir_progress: got %0d want >=5", n_after); end
        $display("test_redirect_inflight done: delivered_after=%0d", n_after);
    endtask

    task automatic test_redirect_wrap();
        int n_after = 0;
        bit first = 1;
        apply_reset();
        iexec_bus.req_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            redir_vld = (i == 8);
            redir_pc = 32'hFFFF_FFF6;
            cyc();
            if (i == 8) begin
                total++; if (s_fhs !== 1'b1 || s_rhs !== 1'b1) begin bad++; $display("FAIL wrap_busy_cycle: got fhs=%b rhs=%b want 1 1", s_fhs, s_rhs); end
            end
            if (i == 9) begin
                total++; if (s_fhs !== 1'b1 || s_faddr !== 32'hFFFF_FFF4) begin bad++; $display("FAIL wrap_refetch: got hs=%b addr=%h want 1 fffffff4", s_fhs, s_faddr); end
            end
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL wrap_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                if (i > 8 && first) begin
                    total++; if (s_rpc !== 32'hFFFF_FFF4) begin bad++; $display("FAIL wrap_first_pc: got %h want fffffff4", s_rpc); end
                    first = 0;
                end
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL wrap_deliver: got pc=%h ir=%h want pc=%h", s_rpc, s_rir, exp_dpc);
                end
                exp_dpc += 32'd4;
                if (i > 8) n_after++;
            end
            if (i == 8) begin
                exp_fa = 32'hFFFF_FFF4;
                exp_dpc = 32'hFFFF_FFF4;
            end
        end
        total++; if (n_after < 8) begin bad++; $display("FAIL wrap_progress: got %0d want >=8", n_after); end
        redir_vld = 1'b0;
        $display("test_redirect_wrap done: delivered_after=%0d", n_after);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        iexec_bus.req_rdy = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        cyc();
        cyc();
        total++; if (s_fvld !== 1'b0) begin bad++; $display("FAIL midrst_fch_vld: got %b want 0", s_fvld); end
        total++; if (s_rvld !== 1'b0) begin bad++; $display("FAIL midrst_req_vld: got %b want 0", s_rvld); end
        rst = 1'b0;
        iexec_bus.req_rdy = 1'b1;
        nd = 0;
        exp_fa = RESET_PC;
        exp_dpc = RESET_PC;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 0) begin
                total++; if (s_fvld !== 1'b1 || s_faddr !== RESET_PC) begin bad++; $display("FAIL midrst_restart: got vld=%b addr=%h want 1 %h", s_fvld, s_faddr, RESET_PC); end
            end
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL midrst_faddr: got %h want %h", s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL midrst_deliver: got pc=%h ir=%h want pc=%h", s_rpc, s_rir, exp_dpc);
                end
                exp_dpc += 32'd4;
            end
        end
        total++; if (nd < 6) begin bad++; $display("FAIL midrst_progress: got %0d want >=6", nd); end
        $display("test_reset_mid done: delivered=%0d", nd);
    endtask

    task automatic test_random();
        bit          hold = 0;
        logic [31:0] hpc, hir, tgt;
        apply_reset();
        bus_rand = 1'b1;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            iexec_bus.req_rdy = ($urandom_range(0, 3) != 0);
            redir_vld = ($urandom_range(0, 39) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            redir_pc = tgt;
            cyc();
            if (hold) begin
                total++;
                if (s_rvld !== 1'b1 || s_rpc !== hpc || s_rir !== hir) begin
                    bad++; $display("FAIL rnd_hold cyc %0d: got vld=%b pc=%h ir=%h want vld=1 pc=%h ir=%h", i, s_rvld, s_rpc, s_rir, hpc, hir);
                end
            end
            if (s_fhs) begin
                total++; if (s_faddr !== exp_fa) begin bad++; $display("FAIL rnd_faddr cyc %0d: got %h want %h", i, s_faddr, exp_fa); end
                exp_fa += 32'd4;
            end
            if (s_rhs) begin
                total++;
                if (s_rpc !== exp_dpc || s_rir !== ir_of(exp_dpc)) begin
                    bad++; $display("FAIL rnd_deliver cyc %0d: got pc=%h ir=%h want pc=%h ir=%h", i, s_rpc, s_rir, exp_dpc, ir_of(exp_dpc));
                end
                exp_dpc += 32'd4;
            end
            total++; if (bq.size() > MAXO) begin bad++; $display("FAIL rnd_outstanding cyc %0d: got %0d want <=%0d", i, bq.size(), MAXO); end
            if (redir_vld) begin
                exp_fa = {tgt[31:2], 2'b00};
                exp_dpc = exp_fa;
            end
            hold = (s_rvld === 1'b1) && (s_rhs !== 1'b1) && !redir_vld;
            hpc = s_rpc;
            hir = s_rir;
        end
        total++; if (nd < 300) begin bad++; $display("FAIL rnd_progress: got %0d want >=300", nd); end
        redir_vld = 1'b0;
        bus_rand = 1'b0;
        lat_max = 1;
        $display("test_random done: fetched=%0d delivered=%0d", nf, nd);
    endtask

    initial begin
        rst = 1'b1;
        fch_req_rdy = 1'b1;
        fch_rsp_vld = 1'b0;
        fch_rsp_data = '0;
        redir_vld = 1'b0;
        redir_pc = '0;
        iexec_bus.req_rdy = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
